// File: rtl/hicore_flush_queue.sv
// Valid/ready decoupling queue. Each entry carries a cancel flag, and the queue can be
// flushed by marking every entry cancelled or by dropping all entries. Optional empty-queue bypass.
`ifndef HiCore_ISSUE2ALU_SIZE
`define HiCore_ISSUE2ALU_SIZE 32
`endif

module hicore_flush_queue #(
  parameter int DW         = `HiCore_ISSUE2ALU_SIZE,
  parameter int DP         = 4,
  parameter int LOGDP      = 2,
  parameter int AFULL_TH   = 3,
  parameter int FLUSH_DROP = 0,
  parameter int BYPASS     = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic            i_cancel,
  input  logic [DW-1:0]   i_info,
  output logic            o_valid,
  input  logic            o_ready,
  output logic            o_cancel,
  output logic [DW-1:0]   o_info,
  input  logic            flush,
  output logic [LOGDP:0]  count,
  output logic            almost_full
);

  localparam logic [LOGDP:0] DP_CNT    = (LOGDP+1)'(DP);
  localparam logic [LOGDP:0] AF_CNT    = (LOGDP+1)'(AFULL_TH);
  localparam logic [LOGDP:0] PTR_ONE   = (LOGDP+1)'(1);
  localparam logic           DROP_MODE = (FLUSH_DROP != 0);
  localparam logic           BYP_MODE  = (BYPASS != 0);

  logic [LOGDP:0]  wr_ptr_q, wr_ptr_d;
  logic [LOGDP:0]  rd_ptr_q, rd_ptr_d;
  logic [DP-1:0]   cancel_q, cancel_d;
  logic [DW-1:0]   mem_q [DP];
  logic [DW-1:0]   mem_d [DP];

  logic [LOGDP-1:0] wr_idx, rd_idx;
  logic             empty, full;
  logic             drop_flush, mark_flush, byp_act;
  logic             wen, ren, wr_en, rd_en;

  assign wr_idx      = wr_ptr_q[LOGDP-1:0];
  assign rd_idx      = rd_ptr_q[LOGDP-1:0];
  assign count       = wr_ptr_q - rd_ptr_q;
  assign empty       = (count == '0);
  assign full        = (count == DP_CNT);
  assign almost_full = (count >= AF_CNT);

  assign drop_flush  = DROP_MODE & flush;
  assign mark_flush  = ~DROP_MODE & flush;
  assign byp_act     = BYP_MODE & empty & ~drop_flush;

  always_comb begin
    i_ready  = ~full & ~drop_flush;
    o_valid  = ~empty & ~drop_flush;
    o_info   = mem_q[rd_idx];
    o_cancel = cancel_q[rd_idx];
    if (byp_act) begin
      o_valid  = i_valid;
      o_info   = i_info;
      o_cancel = i_cancel | mark_flush;
    end
  end

  assign wen   = i_valid & i_ready;
  assign ren   = o_valid & o_ready;
  // A bypassed entry consumed this cycle never touches storage or pointers.
  assign wr_en = wen & ~(byp_act & o_ready);
  assign rd_en = ren & ~byp_act;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (drop_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_comb begin
    cancel_d = cancel_q;
    if (wr_en)      cancel_d[wr_idx] = i_cancel;
    if (mark_flush) cancel_d = '1;
    if (drop_flush) cancel_d = '0;
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_idx] = i_info;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cancel_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cancel_q <= cancel_d;
    end
  end

  // Payload storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: doc/hicore_flush_queue.md
# hicore_flush_queue

Parametrised successor to the core's issue/memory FIFO: a power-of-two-deep, valid/ready buffer carrying a DW-bit payload plus a per-entry cancel flag. Adds a selectable flush policy (mark-cancel or drop), an optional empty-queue bypass, an occupancy count and an almost-full flag. Sits between issue and the ALU/LSU pipes wherever a decoupling queue must absorb pipeline kills.

## Interface
- DW, default `HiCore_ISSUE2ALU_SIZE: payload width
- DP, default 4: depth; must be a power of two, ≥2
- LOGDP, default 2: log2(DP)
- AFULL_TH, default 3: almost_full asserts when count ≥ AFULL_TH; range 1..DP
- FLUSH_DROP, default 0: 0 = flush marks all entries cancelled; 1 = flush empties the queue
- BYPASS, default 0: 1 = empty queue passes input to output in the same cycle
- clk  in  1  clock; everything is rising-edge
- rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  producer has an entry
- i_ready  out  1  queue accepts an entry
- i_cancel  in  1  cancel flag stored with the entry
- i_info  in  DW  payload
- o_valid  out  1  head entry available
- o_ready  in  1  consumer takes head
- o_cancel  out  1  cancel flag of head
- o_info  out  DW  payload of head
- flush  in  1  pipeline kill
- count  out  LOGDP+1  stored entries, 0..DP
- almost_full  out  1  count ≥ AFULL_TH

## Operation
- State: wr_ptr, rd_ptr, each LOGDP+1 bits, wrap modulo 2·DP; DP payload registers (not reset); DP cancel bits (reset 0).
- count = wr_ptr − rd_ptr (LOGDP+1-bit subtraction). empty = (count==0), full = (count==DP).
- wen = i_valid & i_ready; ren = o_valid & o_ready. Write goes to slot wr_ptr[LOGDP-1:0]; head is slot rd_ptr[LOGDP-1:0].
- i_ready = ~full; o_valid = ~empty (modified by flush and bypass below).
- Simultaneous read and write when full: i_ready is 0, so no write; read proceeds. When empty without BYPASS: write proceeds, o_valid stays 0 that cycle.
- Mark-cancel (FLUSH_DROP=0): flush sets every cancel bit to 1 at the edge, including the slot being written that cycle. Pointers, handshakes and payloads unaffected; entries drain with o_cancel=1.
- Drop (FLUSH_DROP=1): in the flush cycle i_ready=0 and o_valid=0 (no handshakes); at the edge wr_ptr, rd_ptr and all cancel bits clear to 0.
- Bypass (BYPASS=1) when empty and not in a drop flush: o_valid=i_valid, o_info=i_info, o_cancel=i_cancel | (flush & ~FLUSH_DROP). If i_valid & o_ready, the entry is consumed and neither pointer moves. If o_ready=0, the entry is written normally.
- Default (no bypass): o_info/o_cancel are the registered head values. A mark flush in the same cycle changes o_cancel only from the next cycle.

## Timing
- Reset values: wr_ptr=rd_ptr=0, count=0, o_valid=0, i_ready=1, almost_full=0, o_cancel=0. o_info is don't-care while o_valid=0.
- Latency without bypass: an entry written at edge N is visible at the head (o_valid=1) in cycle N+1. With bypass and an empty queue: 0 cycles.
- Throughput: one write and one read per cycle, sustained.
- count and almost_full are combinational from the pointers and update the cycle after a handshake. They do not reflect a bypassed entry.
- Pointer wrap: bit LOGDP toggles every DP operations; full/empty stay correct across any number of wraps.
- Reset asserted mid-operation: state returns immediately (asynchronously) to reset values and all entries are lost. After deassertion, the first write is accepted on the first clock edge.
- Flush together with reset: reset wins.

## Test plan
- DP=4, no bypass: write A,B,C,D back-to-back with o_ready=0 → i_ready=0 after D, count=4, almost_full=1 from the cycle after C. Then o_ready=1 → reads A,B,C,D in order, one per cycle, then o_valid=0.
- Continuous write and read for 20 entries (pointer wrap ≥2×) → output order matches input, count stays 1, no drops.
- FLUSH_DROP=0: queue holds 3 entries with cancel=0; flush for 1 cycle while writing E with i_cancel=0 → all 4 entries read with o_cancel=1 and the original payloads.
- FLUSH_DROP=1: queue holds 3 entries; flush with i_valid=1, o_ready=1 → no handshake that cycle; next cycle count=0, o_valid=0, i_ready=1.
- BYPASS=1, empty: i_valid=1, i_info=0x5A, o_ready=1 → o_valid=1, o_info=0x5A the same cycle, count stays 0. Repeat with o_ready=0 → count=1 the next cycle, head=0x5A.
- Assert rst_n=0 asynchronously with 2 entries stored → o_valid=0, count=0 before the next clock edge. After release, one write and one read work normally.
